// File: rtl/stream_fifo_pkg.sv
// Shared defaults and the occupancy-to-flag helper for stream_fifo.
package stream_fifo_pkg;

    localparam int unsigned DefWidth   = 8;
    localparam int unsigned DefDepth   = 8;
    localparam int unsigned DefAeLevel = 1;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_flags_t;

    function automatic fifo_flags_t count_to_flags(int unsigned cnt, int unsigned cap,
                                                   int unsigned af_level, int unsigned ae_level);
        fifo_flags_t f;
        f.empty        = (cnt == 0);
        f.full         = (cnt == cap);
        f.almost_empty = (cnt <= ae_level);
        f.almost_full  = (cnt >= af_level);
        return f;
    endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Storage array for stream_fifo: one synchronous write port, one asynchronous read port, no reset.
module stream_fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [DEPTH-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [DEPTH-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [2**DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_fifo.sv
// Show-ahead synchronous FIFO using all 2^DEPTH entries with registered occupancy flags.
// Sticky overflow/underflow flags exist only when STREAM_FIFO_ERR_FLAGS_EN is defined.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned AF_LEVEL = (1 << DEPTH) - 2,
    parameter int unsigned AE_LEVEL = DefAeLevel
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             enqueue,
    input  logic             dequeue,
    input  logic [WIDTH-1:0] enqueue_data,
    output logic [WIDTH-1:0] queue_head_data,
    output logic [DEPTH:0]   count,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned Cap = 1 << DEPTH;

    logic [DEPTH-1:0] r_head, r_rear;
    logic [DEPTH:0]   r_count, w_count_d;
    fifo_flags_t      r_flags, w_flags_d;
    logic             w_clear, w_do_read, w_do_write;

    // A disabled block behaves exactly like a reset, so both share one clear path.
    assign w_clear    = rst | ~en;
    assign w_do_read  = dequeue & ~r_flags.empty;
    assign w_do_write = enqueue & (~r_flags.full | w_do_read);

    always_comb begin
        w_count_d = r_count;
        if (w_clear) begin
            w_count_d = '0;
        end else if (w_do_write && !w_do_read) begin
            w_count_d = r_count + 1'b1;
        end else if (w_do_read && !w_do_write) begin
            w_count_d = r_count - 1'b1;
        end
        w_flags_d = count_to_flags(int'(w_count_d), Cap, AF_LEVEL, AE_LEVEL);
    end

    always_ff @(posedge clk) begin
        r_count <= w_count_d;
        r_flags <= w_flags_d;
        if (w_clear) begin
            r_head <= '0;
            r_rear <= '0;
        end else begin
            if (w_do_read) begin
                r_head <= r_head + 1'b1;
            end
            if (w_do_write) begin
                r_rear <= r_rear + 1'b1;
            end
        end
    end

    stream_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_do_write & ~w_clear),
        .i_waddr (r_rear),
        .i_wdata (enqueue_data),
        .i_raddr (r_head),
        .o_rdata (queue_head_data)
    );

    assign count        = r_count;
    assign empty        = r_flags.empty;
    assign full         = r_flags.full;
    assign almost_empty = r_flags.almost_empty;
    assign almost_full  = r_flags.almost_full;

`ifdef STREAM_FIFO_ERR_FLAGS_EN
    logic r_overflow, r_underflow;

    // A new error in the same cycle as err_clr wins, so nothing is lost.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow & ~err_clr) | (enqueue & ~w_do_write);
            r_underflow <= (r_underflow & ~err_clr) | (dequeue & r_flags.empty);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, meaning log2 of storage entries; capacity is 2^DEPTH words.
REQ-003 SHALL have parameter AF_LEVEL, default (2^DEPTH)-2, meaning count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 1, meaning count at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  input  1  block enable; low acts as a synchronous flush.
REQ-008 SHALL have port enqueue  input  1  write request.
REQ-009 SHALL have port dequeue  input  1  read request.
REQ-010 SHALL have port enqueue_data  input  WIDTH  write word.
REQ-011 SHALL have port queue_head_data  output  WIDTH  oldest stored word, combinational show-ahead.
REQ-012 SHALL have port count  output  DEPTH+1  current occupancy, 0..2^DEPTH.
REQ-013 SHALL have ports empty, full, almost_empty, almost_full  output  1 each  occupancy flags.
REQ-014 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL accept a write when enqueue=1 and (full=0 or dequeue=1 with empty=0); a write stores enqueue_data at rear and advances rear modulo 2^DEPTH.
REQ-017 SHALL accept a read when dequeue=1 and empty=0; a read advances head modulo 2^DEPTH.
REQ-018 SHALL, on simultaneous accepted read and write, leave count unchanged; when full, a simultaneous read+write is accepted, so the FIFO stays full.
REQ-019 SHALL, when empty, ignore dequeue (no pointer move) even if enqueue=1; the written word is visible on queue_head_data the next cycle (write-to-head latency 1 cycle, no bypass).
REQ-020 SHALL use all 2^DEPTH entries; full is count==2^DEPTH and empty is count==0, both registered-derived, never both 1.
REQ-021 SHALL assert almost_full when count>=AF_LEVEL and almost_empty when count<=AE_LEVEL, updated the same cycle count updates.
REQ-022 SHALL present queue_head_data = storage[head] combinationally; the value is don't-care while empty.
REQ-023 SHALL set overflow when enqueue=1 is rejected (full, no simultaneous accepted read) and underflow when dequeue=1 while empty; both hold until err_clr or reset; err_clr and a new error in the same cycle leaves the flag set.

Reset
REQ-024 SHALL, on rst=1 or en=0 at a rising edge, set head=0, rear=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), overflow=0, underflow=0; stored words are not cleared.
REQ-025 SHALL give rst/en priority over any concurrent enqueue/dequeue; a request in the reset cycle is discarded and does not set error flags.

Configuration
REQ-026 SHALL compile the error logic (REQ-023) only when macro STREAM_FIFO_ERR_FLAGS_EN is defined; without it, overflow and underflow are tied to 0, err_clr is ignored, and no error flops exist.

Structure
REQ-027 SHALL place the default-parameter constants and a count-to-flag helper function in package stream_fifo_pkg.
REQ-028 SHALL instantiate storage as sub-module stream_fifo_ram (one write port, one asynchronous read port, WIDTH x 2^DEPTH, no reset).

Verification (WIDTH=8, DEPTH=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-029 SHALL cover: reset, then 4 writes 0x11..0x44 -> count=4, full=1, almost_full=1 from the 3rd write on; head=0x11.
REQ-030 SHALL cover: 5th write 0x55 while full -> rejected, count stays 4, overflow=1 (macro on) / 0 (macro off); then 4 reads return 0x11,0x22,0x33,0x44 in order.
REQ-031 SHALL cover: dequeue while empty with enqueue=1 data 0xA5 -> head unchanged before write, count=1, underflow=1, next cycle queue_head_data=0xA5.
REQ-032 SHALL cover: full FIFO, simultaneous enqueue 0x66 and dequeue -> count stays 4, 0x66 read out last after 3 more reads, no overflow.
REQ-033 SHALL cover: pointer wrap -- 10 alternating write/read pairs with data 0..9 -> every read matches write order, count alternates 1/0.
REQ-034 SHALL cover: en=0 pulse with count=3 and overflow set -> next cycle count=0, empty=1, overflow=0; err_clr alone clears flags without disturbing count.
